// File: rtl/layer_param_loader.sv
// Streams one layer's inputs, weights and biases into parallel arrays, one word per accepted cycle; params_valid is registered, one cycle after the last word.
// Backpressure: s_ready is low only in HOLD; valid gaps stall the load without losing position.
module layer_param_loader #(
   parameter int INPUT_NEURON_COUNT  = 15,
   parameter int OUTPUT_NEURON_COUNT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic        flush,
   input  logic        params_ack,
   input  logic        keep_weights,
   output logic [15:0] inputs  [0:INPUT_NEURON_COUNT-1],
   output logic [15:0] weights [0:OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT-1],
   output logic [15:0] biases  [0:OUTPUT_NEURON_COUNT-1],
   output logic        params_valid,
   output logic [1:0]  load_phase
);

   localparam int IN    = INPUT_NEURON_COUNT;
   localparam int OUT   = OUTPUT_NEURON_COUNT;
   localparam int NW    = IN * OUT;
   localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

   localparam logic [IDX_W-1:0] LAST_IN = IDX_W'(IN - 1);
   localparam logic [IDX_W-1:0] LAST_W  = IDX_W'(NW - 1);
   localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(OUT - 1);

   localparam logic [1:0] LOAD_IN = 2'd0;
   localparam logic [1:0] LOAD_W  = 2'd1;
   localparam logic [1:0] LOAD_B  = 2'd2;
   localparam logic [1:0] HOLD    = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [IDX_W-1:0] idx;
   logic             reuse;
   logic             xfer;
   logic             wr_en;
   logic             last_word;

   // rst_n gating keeps ready low for the whole reset, not just after the first edge
   assign s_ready    = rst_n && (state != HOLD);
   assign xfer       = s_valid && s_ready;
   assign wr_en      = xfer && !flush;
   assign load_phase = state;

   always_comb begin
      last_word = 1'b0;
      case (state)
         LOAD_IN: last_word = (idx == LAST_IN);
         LOAD_W:  last_word = (idx == LAST_W);
         LOAD_B:  last_word = (idx == LAST_B);
         default: last_word = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = LOAD_IN;
      end else begin
         case (state)
            LOAD_IN: if (xfer && last_word) state_nxt = reuse ? HOLD : LOAD_W;
            LOAD_W:  if (xfer && last_word) state_nxt = LOAD_B;
            LOAD_B:  if (xfer && last_word) state_nxt = HOLD;
            default: if (params_ack)        state_nxt = LOAD_IN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= LOAD_IN;
         idx          <= '0;
         reuse        <= 1'b0;
         params_valid <= 1'b0;
      end else begin
         state        <= state_nxt;
         params_valid <= (state_nxt == HOLD);
         if (flush || (state_nxt != state))
            idx <= '0;
         else if (xfer)
            idx <= idx + 1'b1;
         if (flush)
            reuse <= 1'b0;
         else if ((state == HOLD) && params_ack)
            reuse <= keep_weights;
      end
   end

   // Index compare per element avoids mismatched-width array selects
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < IN; k++)  inputs[k]  <= '0;
         for (int k = 0; k < NW; k++)  weights[k] <= '0;
         for (int k = 0; k < OUT; k++) biases[k]  <= '0;
      end else if (wr_en) begin
         case (state)
            LOAD_IN: for (int k = 0; k < IN; k++)
                        if (idx == IDX_W'(k)) inputs[k] <= s_data;
            LOAD_W:  for (int k = 0; k < NW; k++)
                        if (idx == IDX_W'(k)) weights[k] <= s_data;
            LOAD_B:  for (int k = 0; k < OUT; k++)
                        if (idx == IDX_W'(k)) biases[k] <= s_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed sequence with random data/gaps, checked against a stream-position reference model.
module tb_layer_param_loader;

   localparam int IN    = 15;
   localparam int OUT   = 15;
   localparam int NW    = IN * OUT;
   localparam int TOTAL = IN + NW + OUT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        flush;
   logic        params_ack;
   logic        keep_weights;
   logic [15:0] inputs_o  [0:IN-1];
   logic [15:0] weights_o [0:NW-1];
   logic [15:0] biases_o  [0:OUT-1];
   logic        params_valid;
   logic [1:0]  load_phase;

   int checks = 0;
   int errors = 0;

   // reference model: position in the whole stream, not per-phase counters
   logic [15:0] m_in [IN];
   logic [15:0] m_w  [NW];
   logic [15:0] m_b  [OUT];
   int          m_pos;
   bit          m_hold;
   bit          m_reuse;

   always #5 clk = ~clk;

   layer_param_loader #(.INPUT_NEURON_COUNT(IN), .OUTPUT_NEURON_COUNT(OUT)) dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .flush(flush), .params_ack(params_ack), .keep_weights(keep_weights),
      .inputs(inputs_o), .weights(weights_o), .biases(biases_o),
      .params_valid(params_valid), .load_phase(load_phase)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_phase();
      if (m_hold)               return 3;
      else if (m_pos < IN)      return 0;
      else if (m_pos < IN + NW) return 1;
      else                      return 2;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < IN; k++)  m_in[k] = '0;
      for (int k = 0; k < NW; k++)  m_w[k]  = '0;
      for (int k = 0; k < OUT; k++) m_b[k]  = '0;
      m_pos = 0; m_hold = 0; m_reuse = 0;
   endtask

   task automatic model_step();
      if (flush) begin
         m_pos = 0; m_hold = 0; m_reuse = 0;
      end else if (m_hold) begin
         if (params_ack) begin
            m_hold = 0; m_pos = 0; m_reuse = keep_weights;
         end
      end else if (s_valid) begin
         if (m_pos < IN)           m_in[m_pos] = s_data;
         else if (m_pos < IN + NW) m_w[m_pos - IN] = s_data;
         else                      m_b[m_pos - IN - NW] = s_data;
         m_pos++;
         if ((m_reuse && m_pos == IN) || m_pos == TOTAL) m_hold = 1;
      end
   endtask

   task automatic check_ctrl();
      chk("s_ready", 32'(s_ready), 32'(!m_hold));
      chk("load_phase", 32'(load_phase), 32'(exp_phase()));
      chk("params_valid", 32'(params_valid), 32'(m_hold));
   endtask

   task automatic check_arrays(input string tag);
      for (int k = 0; k < IN; k++)  chk({tag, "_inputs"},  32'(inputs_o[k]),  32'(m_in[k]));
      for (int k = 0; k < NW; k++)  chk({tag, "_weights"}, 32'(weights_o[k]), 32'(m_w[k]));
      for (int k = 0; k < OUT; k++) chk({tag, "_biases"},  32'(biases_o[k]),  32'(m_b[k]));
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
      check_ctrl();
   endtask

   task automatic send(input logic [15:0] d, input int gap);
      s_data = d; s_valid = 1'b1;
      cyc();
      s_valid = 1'b0;
      repeat (gap) cyc();
   endtask

   task automatic ack(input logic k);
      params_ack = 1'b1; keep_weights = k;
      cyc();
      params_ack = 1'b0; keep_weights = 1'b0;
   endtask

   // mode 0: inputs 1..IN, weights 1, biases 5; mode 1: random words
   // gapmode 0: continuous, 1: toggling valid, 2: random gaps
   task automatic load_words(input int first, input int count, input int mode, input int gapmode);
      logic [15:0] d;
      int gap;
      for (int p = first; p < first + count; p++) begin
         if (mode == 0) d = (p < IN) ? 16'(p + 1) : (p < IN + NW) ? 16'd1 : 16'd5;
         else           d = 16'($urandom);
         gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
         if (p == TOTAL - 1) chk("pv_before_last", 32'(params_valid), 32'd0);
         send(d, 0);
         if (p == TOTAL - 1) chk("pv_after_last", 32'(params_valid), 32'd1);
         repeat (gap) cyc();
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_params_valid", 32'(params_valid), 32'd0);
      chk("rst_load_phase", 32'(load_phase), 32'd0);
      check_arrays("rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("post_rst_s_ready", 32'(s_ready), 32'd1);
      chk("post_rst_params_valid", 32'(params_valid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b1; s_data = '0; s_valid = 1'b0; flush = 1'b0;
      params_ack = 1'b0; keep_weights = 1'b0;
      #2;
      do_reset();

      // full continuous load with fixed pattern
      load_words(0, TOTAL, 0, 0);
      chk("hold_s_ready", 32'(s_ready), 32'd0);
      chk("hold_phase", 32'(load_phase), 32'd3);
      check_arrays("full_load");
      repeat (3) cyc();
      chk("hold_stays", 32'(params_valid), 32'd1);

      // weight reuse: only inputs reload
      ack(1'b1);
      for (int i = 0; i < IN; i++) send(16'(100 + i), int'($urandom_range(0, 2)));
      chk("reuse_phase", 32'(load_phase), 32'd3);
      chk("reuse_in0", 32'(inputs_o[0]), 32'd100);
      chk("reuse_w_last", 32'(weights_o[NW-1]), 32'd1);
      chk("reuse_b0", 32'(biases_o[0]), 32'd5);
      check_arrays("reuse");

      // toggling valid; first scribble data so the rewrite is observable
      ack(1'b0);
      load_words(0, TOTAL, 1, 2);
      check_arrays("random_load");
      ack(1'b0);
      load_words(0, TOTAL, 0, 1);
      check_arrays("toggle_load");

      // ack in LOAD_W ignored, then flush on weight #50
      ack(1'b0);
      load_words(0, IN + 10, 1, 2);
      params_ack = 1'b1; keep_weights = 1'b1;
      cyc();
      s_data = 16'h1234; s_valid = 1'b1;
      cyc();
      s_valid = 1'b0;
      cyc();
      params_ack = 1'b0; keep_weights = 1'b0;
      chk("ack_in_w_phase", 32'(load_phase), 32'd1);
      load_words(IN + 11, 38, 1, 0);
      s_data = 16'hDEAD; s_valid = 1'b1; flush = 1'b1; params_ack = 1'b1;
      cyc();
      flush = 1'b0; s_valid = 1'b0; params_ack = 1'b0;
      chk("flush_phase", 32'(load_phase), 32'd0);
      chk("flush_w49_kept", 32'(weights_o[49]), 32'(m_w[49]));
      send(16'h7777, 0);
      chk("flush_restart_in0", 32'(inputs_o[0]), 32'h7777);
      check_arrays("flush");

      // random mix of valid, flush and ack
      for (int c = 0; c < 600; c++) begin
         s_data       = 16'($urandom);
         s_valid      = 1'($urandom_range(0, 1));
         flush        = ($urandom_range(0, 63) == 0);
         params_ack   = ($urandom_range(0, 3) == 0);
         keep_weights = 1'($urandom_range(0, 1));
         cyc();
      end
      s_valid = 1'b0; flush = 1'b0; params_ack = 1'b0; keep_weights = 1'b0;
      check_arrays("random_mix");

      // reset mid-LOAD_B after a reuse request was armed
      flush = 1'b1; cyc(); flush = 1'b0;
      load_words(0, TOTAL, 1, 0);
      ack(1'b1);
      flush = 1'b1; cyc(); flush = 1'b0;
      load_words(0, IN + NW + 7, 1, 0);
      chk("pre_rst_phase", 32'(load_phase), 32'd2);
      do_reset();
      load_words(0, IN, 1, 2);
      chk("rst_full_reload_phase", 32'(load_phase), 32'd1);
      load_words(IN, NW + OUT, 1, 0);
      chk("rst_reload_done", 32'(params_valid), 32'd1);
      check_arrays("after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/layer_param_loader.md
LAYER_PARAM_LOADER -- requirements
Module: layer_param_loader

Interface
REQ-001 SHALL have parameter INPUT_NEURON_COUNT, default 15, the number of input activations per layer pass.
REQ-002 SHALL have parameter OUTPUT_NEURON_COUNT, default 15, the number of output neurons (biases).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port s_data, input, 16 bits: stream word.
REQ-006 SHALL have port s_valid, input, 1 bit: s_data is valid this cycle.
REQ-007 SHALL have port s_ready, output, 1 bit: loader accepts a word this cycle.
REQ-008 SHALL have port flush, input, 1 bit: synchronous restart of the load sequence.
REQ-009 SHALL have port params_ack, input, 1 bit: consumer has taken the parameter set.
REQ-010 SHALL have port keep_weights, input, 1 bit: sampled with params_ack; requests reuse of the current weights and biases.
REQ-011 SHALL have port inputs, output, unpacked array [0:INPUT_NEURON_COUNT-1] of 16 bits: input activations.
REQ-012 SHALL have port weights, output, unpacked array [0:OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT-1] of 16 bits: weights, where weight(out j, in i) is at index j*INPUT_NEURON_COUNT+i.
REQ-013 SHALL have port biases, output, unpacked array [0:OUTPUT_NEURON_COUNT-1] of 16 bits: biases.
REQ-014 SHALL have port params_valid, output, 1 bit: the arrays hold a complete set.
REQ-015 SHALL have port load_phase, output, 2 bits: 0 LOAD_IN, 1 LOAD_W, 2 LOAD_B, 3 HOLD.

Function
REQ-016 SHALL implement FSM states LOAD_IN, LOAD_W, LOAD_B and HOLD, with load_phase equal to the state encoding.
REQ-017 SHALL drive s_ready=1 in LOAD_IN, LOAD_W and LOAD_B, and s_ready=0 in HOLD; s_ready is decoded from state without combinational dependence on s_valid.
REQ-018 SHALL treat a transfer as s_valid&&s_ready at a rising edge; the word is written to the array element selected by a single index counter, which then increments.
REQ-019 SHALL size the index counter to hold OUTPUT_NEURON_COUNT*INPUT_NEURON_COUNT-1; the counter resets to 0 on every state change.
REQ-020 SHALL define stream order as inputs[0..IN-1], then weights[0..OUT*IN-1], then biases[0..OUT-1], where IN = INPUT_NEURON_COUNT and OUT = OUTPUT_NEURON_COUNT.
REQ-021 SHALL make the following transitions on the edge of the last transfer of each phase: LOAD_IN->LOAD_W, LOAD_W->LOAD_B, LOAD_B->HOLD.
REQ-022 SHALL, when the internal reuse flag is set, take LOAD_IN->HOLD on the last input transfer, skipping the weight and bias phases and leaving weights and biases unchanged.
REQ-023 SHALL drive params_valid as a registered output equal to 1 exactly while in HOLD; it rises the cycle after the final transfer.
REQ-024 SHALL treat params_ack in HOLD as: next state LOAD_IN, params_valid=0 next cycle, reuse flag set to keep_weights.
REQ-025 SHALL ignore params_ack and keep_weights outside HOLD.
REQ-026 SHALL, on flush in any state: next state LOAD_IN, index 0, reuse flag cleared, params_valid 0 next cycle.
REQ-027 SHALL give flush priority over a same-cycle transfer (the word is discarded) and over params_ack.
REQ-028 SHALL never clear the arrays except on reset; elements not yet rewritten keep their prior values.
REQ-029 SHALL store data verbatim with no arithmetic; full 16-bit width is preserved.
REQ-030 SHALL let s_valid gaps of any length stall the sequence without losing position.

Reset
REQ-031 SHALL, while rst_n=0, immediately force: state LOAD_IN, index 0, reuse flag 0, params_valid 0, s_ready 0, all inputs/weights/biases elements 0.
REQ-032 SHALL have s_ready=1 in the first cycle after rst_n deasserts; a reset asserted mid-load abandons that load entirely.

Verification
REQ-033 SHALL verify: default params, continuous stream of inputs 1..15, 225 weights of 1, 15 biases of 5 -> params_valid rises 1 cycle after word 255; inputs[i]=i+1, all weights 1, all biases 5; s_ready=0 in HOLD.
REQ-034 SHALL verify: after REQ-033, params_ack with keep_weights=1, then 15 words 100..114 -> HOLD after 15 transfers; inputs[i]=100+i; weights all 1; biases all 5.
REQ-035 SHALL verify: s_valid toggling 1/0 every cycle for a full 255-word load -> identical array contents to REQ-033; params_valid rises 1 cycle after the 255th accepted word.
REQ-036 SHALL verify: flush asserted together with weight transfer #50 -> that word is not written; load_phase=0; next words load into inputs[0].
REQ-037 SHALL verify: rst_n pulsed low mid-LOAD_B -> all arrays 0, params_valid 0 and s_ready 0 immediately while rst_n is low; after release, a full load is again required.
REQ-038 SHALL verify: params_ack asserted in LOAD_W -> no effect on state, counters or params_valid.
